// File: rtl/regfile_fwd_sb_if.sv
// Bundle of every non-clock signal of regfile_fwd_sb.
//   master: ID-stage / pipeline side (drives addresses, forwarding, commits)
//   slave : register file side (returns read data, stalls, busy state)
// Widths follow the register file parameters; instantiate with matching values.
interface regfile_fwd_sb_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_FWD = 3
);
    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam int unsigned FW   = 2 + ADDR_W + DATA_W;

    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rd_stall;
    logic                     stall;
    logic [NUM_FWD*FW-1:0]    fwd_bus;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic [NREG-1:0]          sb_busy;
    logic                     hi_we;
    logic                     lo_we;
    logic [DATA_W-1:0]        hi_wdata;
    logic [DATA_W-1:0]        lo_wdata;
    logic [DATA_W-1:0]        hi_rdata;
    logic [DATA_W-1:0]        lo_rdata;
    logic                     hilo_rd;
    logic                     md_start;
    logic                     md_done;
    logic                     hilo_busy;
    logic                     hilo_stall;

    modport master (
        output raddr, fwd_bus, we, waddr, wdata, sb_set, sb_addr,
               hi_we, lo_we, hi_wdata, lo_wdata, hilo_rd, md_start, md_done,
        input  rdata, rd_stall, stall, sb_busy, hi_rdata, lo_rdata, hilo_busy, hilo_stall
    );

    modport slave (
        input  raddr, fwd_bus, we, waddr, wdata, sb_set, sb_addr,
               hi_we, lo_we, hi_wdata, lo_wdata, hilo_rd, md_start, md_done,
        output rdata, rd_stall, stall, sb_busy, hi_rdata, lo_rdata, hilo_busy, hilo_stall
    );
endinterface

// File: rtl/regfile_fwd_sb.sv
// ID-stage general-purpose register file with forwarding, scoreboard and HI/LO.
//   clk    : clock, all state updates on the rising edge
//   resetn : asynchronous active-low reset, clears regs, HI/LO and busy state
//   bus    : regfile_fwd_sb_if slave modport
//            - raddr/rdata/rd_stall : NUM_RD combinational read ports
//            - fwd_bus              : NUM_FWD sources {we, ready, waddr, wdata}, 0 = youngest
//            - we/waddr/wdata       : commit (WB) write port, also written through to reads
//            - sb_set/sb_addr/sb_busy : long-latency producer scoreboard
//            - hi_*/lo_*            : HI/LO registers with write-through
//            - md_start/md_done/hilo_busy/hilo_rd/hilo_stall : mul/div busy tracking
//            - stall                : OR of all read stalls and hilo_stall
module regfile_fwd_sb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_FWD = 3
) (
    input  logic               clk,
    input  logic               resetn,
    regfile_fwd_sb_if.slave    bus
);
    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam int unsigned FW   = 2 + ADDR_W + DATA_W;

    // Register 0 is never stored
    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [NREG-1:1]   sb_busy_q, sb_busy_d;
    logic [NREG-1:0]   sb_busy_full;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              hilo_busy_q, hilo_busy_d;

    logic [NUM_FWD-1:0] fwd_we, fwd_ready;
    logic [ADDR_W-1:0]  fwd_waddr [NUM_FWD];
    logic [DATA_W-1:0]  fwd_wdata [NUM_FWD];

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              st, hit;

    function automatic logic [DATA_W-1:0] reg_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (a == r[ADDR_W-1:0]) v = regs_q[r];
        end
        return v;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned r = 1; r < NREG; r++) regs_q[r] <= '0;
            sb_busy_q   <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            hilo_busy_q <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (bus.we && bus.waddr == r[ADDR_W-1:0]) regs_q[r] <= bus.wdata;
            end
            sb_busy_q   <= sb_busy_d;
            hilo_busy_q <= hilo_busy_d;
            if (bus.hi_we) hi_q <= bus.hi_wdata;
            if (bus.lo_we) lo_q <= bus.lo_wdata;
        end
    end

    // Set is applied after clear so a new producer issued on the commit cycle stays busy
    always_comb begin
        sb_busy_d = sb_busy_q;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (bus.we && bus.waddr == r[ADDR_W-1:0]) sb_busy_d[r] = 1'b0;
            if (bus.sb_set && bus.sb_addr == r[ADDR_W-1:0]) sb_busy_d[r] = 1'b1;
        end
    end

    assign hilo_busy_d  = bus.md_start | (hilo_busy_q & ~bus.md_done);
    assign sb_busy_full = {sb_busy_q, 1'b0};

    always_comb begin
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            fwd_wdata[k] = bus.fwd_bus[k*FW +: DATA_W];
            fwd_waddr[k] = bus.fwd_bus[k*FW + DATA_W +: ADDR_W];
            fwd_ready[k] = bus.fwd_bus[k*FW + DATA_W + ADDR_W];
            fwd_we[k]    = bus.fwd_bus[k*FW + DATA_W + ADDR_W + 1];
        end
    end

    // Per-port priority: r0, youngest matching forward source, commit write-through,
    // then storage (stalling if a long-latency producer is outstanding)
    always_comb begin
        bus.rdata    = '0;
        bus.rd_stall = '0;
        ra  = '0;
        rd  = '0;
        st  = 1'b0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra  = bus.raddr[i*ADDR_W +: ADDR_W];
            rd  = '0;
            st  = 1'b0;
            hit = 1'b0;
            if (ra != '0) begin
                for (int unsigned k = 0; k < NUM_FWD; k++) begin
                    if (!hit && fwd_we[k] && fwd_waddr[k] == ra) begin
                        hit = 1'b1;
                        rd  = fwd_wdata[k];
                        st  = ~fwd_ready[k];
                    end
                end
                if (!hit) begin
                    if (bus.we && bus.waddr == ra) begin
                        rd = bus.wdata;
                    end else begin
                        rd = reg_read(ra);
                        st = sb_busy_full[ra];
                    end
                end
            end
            bus.rdata[i*DATA_W +: DATA_W] = rd;
            bus.rd_stall[i]               = st;
        end
    end

    assign bus.sb_busy    = sb_busy_full;
    assign bus.hi_rdata   = bus.hi_we ? bus.hi_wdata : hi_q;
    assign bus.lo_rdata   = bus.lo_we ? bus.lo_wdata : lo_q;
    assign bus.hilo_busy  = hilo_busy_q;
    assign bus.hilo_stall = bus.hilo_rd & hilo_busy_q;
    assign bus.stall      = (|bus.rd_stall) | bus.hilo_stall;
endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Directed self-checking bench for regfile_fwd_sb: default configuration (dut_a)
// plus a NUM_RD=3, NUM_FWD=1, ADDR_W=4 configuration (dut_b).
module tb_regfile_fwd_sb;
    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    regfile_fwd_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_FWD(3)) bus_a ();
    regfile_fwd_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .NUM_FWD(1)) bus_b ();

    regfile_fwd_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_FWD(3)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_a)
    );

    regfile_fwd_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .NUM_FWD(1)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] fa(input logic w, input logic r, input logic [4:0] ad,
                                       input logic [31:0] d);
        return {w, r, ad, d};
    endfunction

    function automatic logic [37:0] fb(input logic w, input logic r, input logic [3:0] ad,
                                       input logic [31:0] d);
        return {w, r, ad, d};
    endfunction

    task automatic idle();
        bus_a.raddr = '0; bus_a.fwd_bus = '0; bus_a.we = 0; bus_a.waddr = '0; bus_a.wdata = '0;
        bus_a.sb_set = 0; bus_a.sb_addr = '0; bus_a.hi_we = 0; bus_a.lo_we = 0;
        bus_a.hi_wdata = '0; bus_a.lo_wdata = '0; bus_a.hilo_rd = 0;
        bus_a.md_start = 0; bus_a.md_done = 0;
        bus_b.raddr = '0; bus_b.fwd_bus = '0; bus_b.we = 0; bus_b.waddr = '0; bus_b.wdata = '0;
        bus_b.sb_set = 0; bus_b.sb_addr = '0; bus_b.hi_we = 0; bus_b.lo_we = 0;
        bus_b.hi_wdata = '0; bus_b.lo_wdata = '0; bus_b.hilo_rd = 0;
        bus_b.md_start = 0; bus_b.md_done = 0;
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after posedge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        bus_a.raddr = {5'd1, 5'd5};
        #1;
        checks++; if (bus_a.sb_busy !== 32'h0) begin failures++;
            $display("FAIL rst_sb_busy got=%h want=0", bus_a.sb_busy); end
        checks++; if (bus_a.hilo_busy !== 1'b0) begin failures++;
            $display("FAIL rst_hilo_busy got=%b want=0", bus_a.hilo_busy); end
        checks++; if (bus_a.rdata !== 64'h0) begin failures++;
            $display("FAIL rst_rdata got=%h want=0", bus_a.rdata); end
        checks++; if ({bus_a.hi_rdata, bus_a.lo_rdata} !== 64'h0) begin failures++;
            $display("FAIL rst_hilo got=%h want=0", {bus_a.hi_rdata, bus_a.lo_rdata}); end
        checks++; if (bus_a.stall !== 1'b0) begin failures++;
            $display("FAIL rst_stall got=%b want=0", bus_a.stall); end
        #3 resetn = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        idle();
        bus_a.we = 1; bus_a.waddr = 5'd5; bus_a.wdata = 32'hDEADBEEF;
        bus_a.raddr = {5'd0, 5'd5};
        #1;
        checks++; if (bus_a.rdata[31:0] !== 32'hDEADBEEF) begin failures++;
            $display("FAIL wr_through got=%h want=deadbeef", bus_a.rdata[31:0]); end
        step();
        idle();
        bus_a.raddr = {5'd0, 5'd5};
        bus_a.we = 1; bus_a.waddr = 5'd0; bus_a.wdata = 32'h1234;
        #1;
        checks++; if (bus_a.rdata[31:0] !== 32'hDEADBEEF) begin failures++;
            $display("FAIL wr_stored got=%h want=deadbeef", bus_a.rdata[31:0]); end
        checks++; if (bus_a.rdata[63:32] !== 32'h0) begin failures++;
            $display("FAIL r0_zero got=%h want=0", bus_a.rdata[63:32]); end
        step();
        idle();
        bus_a.raddr = {5'd0, 5'd5};
        #1;
        checks++; if (bus_a.rdata !== {32'h0, 32'hDEADBEEF}) begin failures++;
            $display("FAIL r0_after got=%h want=0_deadbeef", bus_a.rdata); end
        step();
    endtask

    task automatic test_fwd_priority();
        idle();
        bus_a.raddr = {5'd0, 5'd7};
        bus_a.fwd_bus = {fa(1, 1, 5'd7, 32'h33), fa(0, 0, 5'd0, 32'h0), fa(1, 1, 5'd7, 32'h11)};
        #1;
        checks++; if (bus_a.rdata[31:0] !== 32'h11 || bus_a.stall !== 1'b0) begin failures++;
            $display("FAIL fwd_young got=%h/%b want=11/0", bus_a.rdata[31:0], bus_a.stall); end
        bus_a.fwd_bus = {fa(1, 1, 5'd7, 32'h33), fa(0, 0, 5'd0, 32'h0), fa(1, 0, 5'd7, 32'h11)};
        #1;
        checks++; if (bus_a.rd_stall !== 2'b01 || bus_a.stall !== 1'b1) begin failures++;
            $display("FAIL fwd_notready got=%b/%b want=01/1", bus_a.rd_stall, bus_a.stall); end
        bus_a.fwd_bus = {fa(1, 1, 5'd7, 32'h33), fa(0, 0, 5'd0, 32'h0), fa(0, 0, 5'd7, 32'h11)};
        bus_a.we = 1; bus_a.waddr = 5'd7; bus_a.wdata = 32'h99;
        #1;
        checks++; if (bus_a.rdata[31:0] !== 32'h33 || bus_a.stall !== 1'b0) begin failures++;
            $display("FAIL fwd_old got=%h/%b want=33/0", bus_a.rdata[31:0], bus_a.stall); end
        step();
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        bus_a.sb_set = 1; bus_a.sb_addr = 5'd9;
        step();
        idle();
        bus_a.raddr = {5'd0, 5'd9};
        #1;
        checks++; if (bus_a.sb_busy !== 32'h200) begin failures++;
            $display("FAIL sb_set got=%h want=200", bus_a.sb_busy); end
        checks++; if (bus_a.rd_stall !== 2'b01 || bus_a.stall !== 1'b1) begin failures++;
            $display("FAIL sb_stall got=%b/%b want=01/1", bus_a.rd_stall, bus_a.stall); end
        bus_a.we = 1; bus_a.waddr = 5'd9; bus_a.wdata = 32'h55;
        #1;
        checks++; if (bus_a.rdata[31:0] !== 32'h55 || bus_a.stall !== 1'b0) begin failures++;
            $display("FAIL sb_commit got=%h/%b want=55/0", bus_a.rdata[31:0], bus_a.stall); end
        step();
        idle();
        #1;
        checks++; if (bus_a.sb_busy !== 32'h0) begin failures++;
            $display("FAIL sb_clear got=%h want=0", bus_a.sb_busy); end
        bus_a.sb_set = 1; bus_a.sb_addr = 5'd9;
        bus_a.we = 1; bus_a.waddr = 5'd9; bus_a.wdata = 32'h66;
        step();
        idle();
        bus_a.sb_set = 1; bus_a.sb_addr = 5'd0;
        #1;
        checks++; if (bus_a.sb_busy !== 32'h200) begin failures++;
            $display("FAIL sb_set_wins got=%h want=200", bus_a.sb_busy); end
        step();
        idle();
        bus_a.we = 1; bus_a.waddr = 5'd9; bus_a.wdata = 32'h66;
        step();
        idle();
        #1;
        checks++; if (bus_a.sb_busy !== 32'h0) begin failures++;
            $display("FAIL sb_addr0 got=%h want=0", bus_a.sb_busy); end
    endtask

    task automatic test_hilo();
        idle();
        bus_a.md_start = 1;
        step();
        idle();
        bus_a.hilo_rd = 1;
        #1;
        checks++; if (bus_a.hilo_stall !== 1'b1 || bus_a.stall !== 1'b1) begin failures++;
            $display("FAIL hilo_stall got=%b/%b want=1/1", bus_a.hilo_stall, bus_a.stall); end
        bus_a.hi_we = 1; bus_a.hi_wdata = 32'hA; bus_a.lo_we = 1; bus_a.lo_wdata = 32'hB;
        bus_a.md_done = 1;
        #1;
        checks++; if (bus_a.hi_rdata !== 32'hA || bus_a.lo_rdata !== 32'hB) begin failures++;
            $display("FAIL hilo_wt got=%h/%h want=a/b", bus_a.hi_rdata, bus_a.lo_rdata); end
        step();
        idle();
        bus_a.hilo_rd = 1;
        #1;
        checks++; if (bus_a.hilo_busy !== 1'b0 || bus_a.hilo_stall !== 1'b0) begin failures++;
            $display("FAIL hilo_done got=%b/%b want=0/0", bus_a.hilo_busy, bus_a.hilo_stall); end
        checks++; if (bus_a.hi_rdata !== 32'hA || bus_a.lo_rdata !== 32'hB) begin failures++;
            $display("FAIL hilo_stored got=%h/%h want=a/b", bus_a.hi_rdata, bus_a.lo_rdata); end
        bus_a.md_start = 1; bus_a.md_done = 1;
        step();
        idle();
        #1;
        checks++; if (bus_a.hilo_busy !== 1'b1) begin failures++;
            $display("FAIL hilo_both got=%b want=1", bus_a.hilo_busy); end
        bus_a.md_done = 1;
        step();
        step();
        #1;
        checks++; if (bus_a.hilo_busy !== 1'b0) begin failures++;
            $display("FAIL hilo_idle_done got=%b want=0", bus_a.hilo_busy); end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        bus_a.sb_set = 1; bus_a.sb_addr = 5'd3;
        bus_a.we = 1; bus_a.waddr = 5'd3; bus_a.wdata = 32'h77;
        bus_a.md_start = 1;
        step();
        idle();
        bus_a.raddr = {5'd0, 5'd3};
        #1;
        checks++; if (bus_a.sb_busy !== 32'h8 || bus_a.hilo_busy !== 1'b1) begin failures++;
            $display("FAIL pre_rst got=%h/%b want=8/1", bus_a.sb_busy, bus_a.hilo_busy); end
        #1 resetn = 1'b0;
        #1;
        checks++; if (bus_a.sb_busy !== 32'h0 || bus_a.hilo_busy !== 1'b0) begin failures++;
            $display("FAIL async_busy got=%h/%b want=0/0", bus_a.sb_busy, bus_a.hilo_busy); end
        checks++; if (bus_a.rdata[31:0] !== 32'h0 || bus_a.stall !== 1'b0) begin failures++;
            $display("FAIL async_rdata got=%h/%b want=0/0", bus_a.rdata[31:0], bus_a.stall); end
        #1 resetn = 1'b1;
        step();
    endtask

    task automatic test_sweep();
        idle();
        bus_b.we = 1; bus_b.waddr = 4'd15; bus_b.wdata = 32'hF00D;
        step();
        idle();
        bus_b.we = 1; bus_b.waddr = 4'd0; bus_b.wdata = 32'hBAD;
        step();
        idle();
        bus_b.raddr = {4'd7, 4'd0, 4'd15};
        #1;
        checks++; if (bus_b.rdata !== {32'h0, 32'h0, 32'hF00D}) begin failures++;
            $display("FAIL sw_read got=%h want=0_0_f00d", bus_b.rdata); end
        bus_b.raddr = {4'd15, 4'd15, 4'd1};
        bus_b.fwd_bus = fb(1, 0, 4'd15, 32'hCAFE);
        #1;
        checks++; if (bus_b.rd_stall !== 3'b110 || bus_b.stall !== 1'b1) begin failures++;
            $display("FAIL sw_fwd got=%b/%b want=110/1", bus_b.rd_stall, bus_b.stall); end
        bus_b.fwd_bus = fb(1, 1, 4'd1, 32'hBEEF);
        bus_b.we = 1; bus_b.waddr = 4'd15; bus_b.wdata = 32'h1111;
        #1;
        checks++; if (bus_b.rdata !== {32'h1111, 32'h1111, 32'hBEEF}) begin failures++;
            $display("FAIL sw_wt got=%h want=1111_1111_beef", bus_b.rdata); end
        step();
        idle();
        bus_b.sb_set = 1; bus_b.sb_addr = 4'd15;
        step();
        idle();
        bus_b.sb_set = 1; bus_b.sb_addr = 4'd0;
        bus_b.raddr = {4'd0, 4'd15, 4'd0};
        step();
        #1;
        checks++; if (bus_b.sb_busy !== 16'h8000) begin failures++;
            $display("FAIL sw_sb got=%h want=8000", bus_b.sb_busy); end
        checks++; if (bus_b.rd_stall !== 3'b010 || bus_b.rdata[63:32] !== 32'h1111) begin
            failures++;
            $display("FAIL sw_sb_rd got=%b/%h want=010/1111", bus_b.rd_stall, bus_b.rdata[63:32]);
        end
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        test_reset();
        test_write_read();
        test_fwd_priority();
        test_scoreboard();
        test_hilo();
        test_async_reset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
